// File: rtl/ir_tx_1506.sv
// ir_tx_1506: Avalon-MM NEC infrared transmitter with carrier modulation on export_ir_tx.
// Optional feature: define IR_TX_REPEAT_EN to enable CTRL.repeat and NEC repeat codes.
module ir_tx_1506 #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        export_ir_tx
);

    localparam int UNIT_W = $clog2(16 * UNIT_CYCLES + 1);
    localparam logic [UNIT_W-1:0] LAST_1U      = UNIT_W'(UNIT_CYCLES - 1);
    localparam logic [UNIT_W-1:0] LAST_3U      = UNIT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [UNIT_W-1:0] LAST_8U      = UNIT_W'(8 * UNIT_CYCLES - 1);
    localparam logic [UNIT_W-1:0] LAST_16U     = UNIT_W'(16 * UNIT_CYCLES - 1);
    localparam logic [UNIT_W-1:0] CARRIER_LAST = UNIT_W'(CARRIER_HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    state_t            state;
    logic [UNIT_W-1:0] unit_cnt;
    logic [UNIT_W-1:0] carrier_cnt;
    logic [UNIT_W-1:0] phase_last;
    logic [5:0]        bit_cnt;
    logic [31:0]       frame_data;
    logic              done;
    logic              busy;
    logic              in_mark;
    logic              phase_end;
    logic              tx_accept;
    logic              status_read;
    logic              ctrl_repeat;
    logic              unused_wdata;

`ifdef IR_TX_REPEAT_EN
    localparam int FRAME_W = $clog2(192 * UNIT_CYCLES);
    localparam logic [UNIT_W-1:0]  LAST_4U  = UNIT_W'(4 * UNIT_CYCLES - 1);
    localparam logic [FRAME_W-1:0] GAP_LAST = FRAME_W'(192 * UNIT_CYCLES - 1);

    logic [FRAME_W-1:0] frame_cnt;
    logic               is_repeat;
`endif

    assign busy         = (state != IDLE);
    assign in_mark      = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
    assign tx_accept    = avs_write && (avs_address == 2'd0) && (state == IDLE);
    assign status_read  = avs_read && (avs_address == 2'd1);
    assign phase_end    = (unit_cnt == phase_last);
    assign unused_wdata = ^avs_writedata[31:16];

    always_comb begin
        phase_last = LAST_1U;
        case (state)
            LEAD_MARK:  phase_last = LAST_16U;
`ifdef IR_TX_REPEAT_EN
            LEAD_SPACE: phase_last = is_repeat ? LAST_4U : LAST_8U;
`else
            LEAD_SPACE: phase_last = LAST_8U;
`endif
            BIT_SPACE:  phase_last = frame_data[bit_cnt[4:0]] ? LAST_3U : LAST_1U;
            default:    phase_last = LAST_1U;
        endcase
    end

`ifdef IR_TX_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_repeat <= 1'b0;
        end else if (avs_write && (avs_address == 2'd2)) begin
            ctrl_repeat <= avs_writedata[0];
        end
    end
`else
    assign ctrl_repeat = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                2'd1:    avs_readdata <= {30'd0, done, busy};
                2'd2:    avs_readdata <= {31'd0, ctrl_repeat};
                default: avs_readdata <= '0;
            endcase
        end
    end

    // Every mark entry restarts the unit and carrier counters with the LED already high,
    // so the first clock of each mark drives the carrier's high half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            unit_cnt     <= '0;
            carrier_cnt  <= '0;
            bit_cnt      <= '0;
            frame_data   <= '0;
            done         <= 1'b0;
            export_ir_tx <= 1'b0;
`ifdef IR_TX_REPEAT_EN
            frame_cnt    <= '0;
            is_repeat    <= 1'b0;
`endif
        end else begin
            if (status_read) begin
                done <= 1'b0;
            end
            if ((state != IDLE) && (state != GAP)) begin
                unit_cnt <= unit_cnt + UNIT_W'(1);
            end
`ifdef IR_TX_REPEAT_EN
            if (state != IDLE) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
`endif
            if (in_mark) begin
                if (carrier_cnt == CARRIER_LAST) begin
                    carrier_cnt  <= '0;
                    export_ir_tx <= ~export_ir_tx;
                end else begin
                    carrier_cnt <= carrier_cnt + UNIT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (tx_accept) begin
                        frame_data   <= {~avs_writedata[15:8], avs_writedata[15:8],
                                         ~avs_writedata[7:0], avs_writedata[7:0]};
                        bit_cnt      <= '0;
                        done         <= 1'b0;
                        state        <= LEAD_MARK;
                        unit_cnt     <= '0;
                        carrier_cnt  <= '0;
                        export_ir_tx <= 1'b1;
`ifdef IR_TX_REPEAT_EN
                        frame_cnt    <= '0;
                        is_repeat    <= 1'b0;
`endif
                    end
                end
                LEAD_MARK: begin
                    if (phase_end) begin
                        state        <= LEAD_SPACE;
                        unit_cnt     <= '0;
                        export_ir_tx <= 1'b0;
                    end
                end
                LEAD_SPACE: begin
                    if (phase_end) begin
                        unit_cnt     <= '0;
                        carrier_cnt  <= '0;
                        export_ir_tx <= 1'b1;
`ifdef IR_TX_REPEAT_EN
                        state        <= is_repeat ? STOP_MARK : BIT_MARK;
`else
                        state        <= BIT_MARK;
`endif
                    end
                end
                BIT_MARK: begin
                    if (phase_end) begin
                        state        <= BIT_SPACE;
                        unit_cnt     <= '0;
                        export_ir_tx <= 1'b0;
                    end
                end
                BIT_SPACE: begin
                    if (phase_end) begin
                        unit_cnt     <= '0;
                        carrier_cnt  <= '0;
                        export_ir_tx <= 1'b1;
                        bit_cnt      <= bit_cnt + 6'd1;
                        state        <= (bit_cnt == 6'd31) ? STOP_MARK : BIT_MARK;
                    end
                end
                STOP_MARK: begin
                    if (phase_end) begin
                        unit_cnt     <= '0;
                        export_ir_tx <= 1'b0;
`ifdef IR_TX_REPEAT_EN
                        if (ctrl_repeat) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
`else
                        state        <= IDLE;
                        done         <= 1'b1;
`endif
                    end
                end
`ifdef IR_TX_REPEAT_EN
                // The gap pads each frame or repeat code out to 192 units from its own start.
                GAP: begin
                    if (frame_cnt == GAP_LAST) begin
                        state        <= LEAD_MARK;
                        frame_cnt    <= '0;
                        is_repeat    <= 1'b1;
                        unit_cnt     <= '0;
                        carrier_cnt  <= '0;
                        export_ir_tx <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ir_tx_1506.md
IR_TX_1506 -- requirements
Module: ir_tx_1506

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 28125; clocks per 562.5 us NEC unit at 50 MHz.
REQ-002 SHALL have parameter CARRIER_HALF, default 658; clocks per carrier half-period (38 kHz at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock; the block uses this single clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port avs_address  input  2  Avalon-MM register select.
REQ-006 SHALL have port avs_write  input  1  write strobe.
REQ-007 SHALL have port avs_writedata  input  32  write data.
REQ-008 SHALL have port avs_read  input  1  read strobe.
REQ-009 SHALL have port avs_readdata  output  32  read data, registered.
REQ-010 SHALL have port export_ir_tx  output  1  modulated IR LED drive, conduit.

Function
REQ-011 Registers SHALL be: addr 0 TX (write: [7:0] address, [15:8] command, the write starts a frame); addr 1 STATUS (read: bit0 busy, bit1 done); addr 2 CTRL (read/write: bit0 repeat).
REQ-012 avs_readdata SHALL be valid one clock after avs_read; unused bits SHALL read 0.
REQ-013 A TX write while busy=1 SHALL be ignored with no side effects.
REQ-014 A frame SHALL transmit these fields, each byte LSB first: address, ~address, command, ~command.
REQ-015 The FSM SHALL have states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, and GAP.
REQ-016 The FSM SHALL move from IDLE to LEAD_MARK on the clock after an accepted TX write; busy SHALL be 1 from that clock onward.
REQ-017 Mark/space durations SHALL be: LEAD_MARK 16 units, LEAD_SPACE 8 units, BIT_MARK 1 unit, BIT_SPACE 1 unit for a 0 and 3 units for a 1, STOP_MARK 1 unit.
REQ-018 A 6-bit bit counter SHALL advance after each BIT_SPACE; after bit 31 the FSM SHALL go to STOP_MARK.
REQ-019 During any MARK state export_ir_tx SHALL toggle every CARRIER_HALF clocks, starting high on the first mark clock; the carrier counter SHALL restart at each mark entry.
REQ-020 In all other states export_ir_tx SHALL be 0.
REQ-021 Leaving STOP_MARK without repeat SHALL return the FSM to IDLE, clear busy, and set done.
REQ-022 done SHALL clear when STATUS is read or a TX write is accepted; if both happen in the same clock, the TX write wins.
REQ-023 Unit and carrier counters SHALL be wide enough for 16*UNIT_CYCLES without wrap.
REQ-024 Total frame length SHALL equal (16+8+2*32+2*ones+1)*UNIT_CYCLES clocks, where ones is the count of 1 bits in the frame.

Reset
REQ-025 While reset=1 the FSM SHALL be in IDLE with all counters cleared.
REQ-026 While reset=1: busy=0, done=0, CTRL=0, avs_readdata=0, export_ir_tx=0.
REQ-027 Reset asserted mid-frame SHALL force export_ir_tx low in the same cycle (asynchronously) and abandon the frame.

Configuration
REQ-028 With IR_TX_REPEAT_EN defined and CTRL.repeat=1 at STOP_MARK exit, the FSM SHALL enter GAP and pad to 192 units from frame start.
REQ-029 It SHALL then send a repeat code: 16-unit mark, 4-unit space, 1-unit mark, then GAP again.
REQ-030 Repeat codes SHALL continue while CTRL.repeat=1; when it is 0 at the end of a repeat code, the FSM SHALL return to IDLE and set done.
REQ-031 Without IR_TX_REPEAT_EN, CTRL bit0 SHALL read 0, writes to it SHALL be ignored, and there SHALL be no GAP state logic.

Verification
REQ-032 Reset, then read STATUS -> readdata=0; export_ir_tx=0.
REQ-033 Write TX=0x0000_BC00 (command 0xBC, address 0x00) -> leader 9 ms mark with 38 kHz toggling; 32 bits decode to 0x00,0xFF,0xBC,0x43; stop mark; then done=1 and busy=0.
REQ-034 Write TX=0x0012 while busy -> frame content unchanged; a second frame never starts.
REQ-035 Assert reset at bit 10 -> export_ir_tx=0 immediately; after release, STATUS=0.
REQ-036 With IR_TX_REPEAT_EN: CTRL=1, TX=0x0000_0145 -> next leader starts 108 ms after frame start; leader space 2.25 ms; repeats stop after CTRL=0.
REQ-037 Read STATUS after done -> bit1=1; the following read -> bit1=0.
